// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Purpose  : 16x-oversampled UART receiver with 2-of-3 bit voting, optional
//            even/odd parity and per-frame parity / stop-bit error strobes.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err,
  output logic                  busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] c_SMP_LO  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] c_SMP_MID = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] c_SMP_DEC = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] c_SMP_END = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] c_BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              sync_q, sync_d;
  logic                    rxs_dly_q, rxs_dly_d;
  logic [CW-1:0]           smp_cnt_q, smp_cnt_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    v_lo_q, v_lo_d;
  logic                    v_mid_q, v_mid_d;
  logic                    pen_q, pen_d;
  logic                    ptyp_q, ptyp_d;
  logic                    perr_flag_q, perr_flag_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    dv_q, dv_d;
  logic                    pe_q, pe_d;
  logic                    se_q, se_d;
  logic                    busy_q, busy_d;

  logic w_rxs;
  logic w_maj;
  logic w_at_dec;
  logic w_at_end;

  assign w_rxs    = sync_q[1];
  assign w_maj    = (v_lo_q & v_mid_q) | (v_lo_q & w_rxs) | (v_mid_q & w_rxs);
  assign w_at_dec = (smp_cnt_q == c_SMP_DEC);
  assign w_at_end = (smp_cnt_q == c_SMP_END);

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], rx_in};
    rxs_dly_d   = w_rxs;
    smp_cnt_d   = smp_cnt_q + CW'(1);
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    v_lo_d      = (smp_cnt_q == c_SMP_LO)  ? w_rxs : v_lo_q;
    v_mid_d     = (smp_cnt_q == c_SMP_MID) ? w_rxs : v_mid_q;
    pen_d       = pen_q;
    ptyp_d      = ptyp_q;
    perr_flag_d = perr_flag_q;
    rx_data_d   = rx_data_q;
    dv_d        = 1'b0;
    pe_d        = 1'b0;
    se_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        smp_cnt_d = '0;
        // The detection cycle itself is sample 0 of the start bit.
        if (rxs_dly_q && !w_rxs) begin
          state_d     = S_START;
          smp_cnt_d   = CW'(1);
          bit_cnt_d   = '0;
          pen_d       = par_en;
          ptyp_d      = par_typ;
          perr_flag_d = 1'b0;
        end
      end
      S_START: begin
        if (w_at_dec && w_maj) begin
          state_d   = S_IDLE;
          smp_cnt_d = '0;
        end else if (w_at_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (w_at_dec) begin
          shreg_d = {w_maj, shreg_q[DATA_WIDTH-1:1]};
        end
        if (w_at_end) begin
          if (bit_cnt_q == c_BIT_LAST) begin
            state_d   = pen_q ? S_PARITY : S_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_at_dec && (w_maj != (^shreg_q ^ ptyp_q))) begin
          perr_flag_d = 1'b1;
        end
        if (w_at_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Leave at the decision point so a start edge late in the stop bit is caught.
        if (w_at_dec) begin
          state_d   = S_IDLE;
          smp_cnt_d = '0;
          se_d      = ~w_maj;
          pe_d      = perr_flag_q;
          if (w_maj && !perr_flag_q) begin
            rx_data_d = shreg_q;
            dv_d      = 1'b1;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        smp_cnt_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      rxs_dly_q   <= 1'b1;
      smp_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      v_lo_q      <= 1'b1;
      v_mid_q     <= 1'b1;
      pen_q       <= 1'b0;
      ptyp_q      <= 1'b0;
      perr_flag_q <= 1'b0;
      rx_data_q   <= '0;
      dv_q        <= 1'b0;
      pe_q        <= 1'b0;
      se_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rxs_dly_q   <= rxs_dly_d;
      smp_cnt_q   <= smp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      v_lo_q      <= v_lo_d;
      v_mid_q     <= v_mid_d;
      pen_q       <= pen_d;
      ptyp_q      <= ptyp_d;
      perr_flag_q <= perr_flag_d;
      rx_data_q   <= rx_data_d;
      dv_q        <= dv_d;
      pe_q        <= pe_d;
      se_q        <= se_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign data_valid = dv_q;
  assign par_err    = pe_q;
  assign stop_err   = se_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_core
// Purpose  : Self-checking bench for uart_rx_core (frame table + scoreboard).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_core;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic       par_typ;
  logic [7:0] rx_data;
  logic       data_valid;
  logic       par_err;
  logic       stop_err;
  logic       busy;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       pbit;
    logic       stop;
    int         pa;
    int         pb;
    int         gap;
    logic       ev;
    logic       eperr;
    logic       eserr;
    logic [7:0] edata;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       v;
    logic       p;
    logic       s;
    int         t;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[10];

  uart_rx_core #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .rx_data    (rx_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stop_err   (stop_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  // Any output strobe must correspond to the oldest outstanding frame.
  always @(negedge clk) begin
    if (rst && (data_valid || par_err || stop_err)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pulse: got dv=%0d pe=%0d se=%0d expected none at cycle %0d",
                 data_valid, par_err, stop_err, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("pulse_cycle", cyc, mon_e.t);
        chk("data_valid", int'(data_valid), int'(mon_e.v));
        chk("par_err", int'(par_err), int'(mon_e.p));
        chk("stop_err", int'(stop_err), int'(mon_e.s));
        chk("rx_data", int'(rx_data), int'(mon_e.data));
      end
    end
  end

  function automatic logic frame_bit(input vec_t v, input int i);
    if (i == 0)             return 1'b0;
    if (i <= 8)             return v.data[i-1];
    if (i == 9 && v.pe)     return v.pbit;
    return v.stop;
  endfunction

  // Called at a negedge; par_en/par_typ are flipped after the start bit to
  // confirm the receiver uses the values latched at start detection.
  task automatic send_frame(input vec_t v);
    exp_t e;
    int   nbits;
    nbits   = v.pe ? 11 : 10;
    par_en  = v.pe;
    par_typ = v.pt;
    e.data  = v.edata;
    e.v     = v.ev;
    e.p     = v.eperr;
    e.s     = v.eserr;
    e.t     = cyc + 156 + (v.pe ? 16 : 0);
    sb.push_back(e);
    for (int i = 0; i < nbits; i++) begin
      rx_in = frame_bit(v, i);
      if (i == 1) begin
        par_en  = ~v.pe;
        par_typ = ~v.pt;
      end
      repeat ((i % 2 == 0) ? v.pa : v.pb) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (v.gap) @(negedge clk);
  endtask

  initial begin
    int n;
    vec_t hv;

    rst     = 1'b0;
    rx_in   = 1'b1;
    par_en  = 1'b0;
    par_typ = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_data_valid", int'(data_valid), 0);
    chk("reset_par_err", int'(par_err), 0);
    chk("reset_stop_err", int'(stop_err), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    //            data   pe    pt    pbit  stop  pa  pb  gap  ev    eperr eserr edata
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 16, 16, 20, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 16, 16, 20, 1'b1, 1'b0, 1'b0, 8'h3C};
    tbl[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 16, 16, 20, 1'b0, 1'b1, 1'b0, 8'h3C};
    tbl[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 16, 16, 20, 1'b0, 1'b0, 1'b1, 8'h3C};
    tbl[4] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 16, 16, 20, 1'b1, 1'b0, 1'b0, 8'h81};
    tbl[5] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 16, 16, 20, 1'b1, 1'b0, 1'b0, 8'hA5};
    tbl[6] = '{8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 16, 16, 20, 1'b0, 1'b1, 1'b1, 8'hA5};
    tbl[7] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 15, 17,  0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[8] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 15, 17,  0, 1'b1, 1'b0, 1'b0, 8'hFF};
    tbl[9] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 15, 17, 20, 1'b1, 1'b0, 1'b0, 8'hC3};

    for (int i = 0; i < 10; i++) begin
      send_frame(tbl[i]);
    end

    // Start glitch: 4 low cycles must be rejected with no strobes.
    n = cyc;
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch_busy_rise", int'(busy), 1);
    @(negedge clk);
    rx_in = 1'b1;
    repeat (n + 12 - cyc) @(negedge clk);
    chk("glitch_busy_drop", int'(busy), 0);
    repeat (20) @(negedge clk);
    hv = '{8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 16, 16, 20, 1'b1, 1'b0, 1'b0, 8'h7E};
    send_frame(hv);

    // Asynchronous reset during data bit 3 of 0xFF.
    par_en = 1'b0;
    rx_in  = 1'b0;
    repeat (16) @(negedge clk);
    rx_in  = 1'b1;
    repeat (48 + 8) @(negedge clk);
    chk("midframe_busy", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_rx_data", int'(rx_data), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_data_valid", int'(data_valid), 0);
    chk("async_rst_flags", int'({par_err, stop_err}), 0);
    @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    hv = '{8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 16, 16, 20, 1'b1, 1'b0, 1'b0, 8'h12};
    send_frame(hv);

    repeat (200) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receiver core for the UART RX path. Runs on the 16x-oversample clock produced by the RX clock divider, synchronises the `rx_in` line, and detects the start bit. It majority-votes each bit and reassembles an 8-bit LSB-first frame with optional parity. It outputs the received byte with a one-cycle valid strobe and per-frame parity and stop-bit error flags to the downstream consumer (FIFO or register file).

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `OVERSAMPLE`, default 16: clock cycles per bit. Must be a power of two, ≥ 8.

Ports:
- `clk`  in  1  16x-oversample clock from the RX clock divider. This is the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_in`  in  1  raw serial line. Idle high. Asynchronous to `clk`.
- `par_en`  in  1  1 = a parity bit follows the data bits.
- `par_typ`  in  1  0 = even parity, 1 = odd parity.
- `rx_data`  out  DATA_WIDTH  last error-free byte received.
- `data_valid`  out  1  one-cycle pulse when `rx_data` is updated.
- `par_err`  out  1  one-cycle pulse on a parity mismatch.
- `stop_err`  out  1  one-cycle pulse when the stop bit is sampled 0.
- `busy`  out  1  high from start-bit acceptance until the stop-bit decision.

## Operation
- **Synchroniser:** `rx_in` passes through a 2-flop synchroniser, reset value 1. All logic below uses the synchronised value `rxs` and its 1-cycle delayed copy `rxs_d`.
- **Counters:** `smp_cnt` has log2(OVERSAMPLE) bits and wraps naturally. `bit_cnt` counts data bits, 0..DATA_WIDTH-1.
- **Voting:** samples are taken at `smp_cnt` = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 (7, 8, 9 for the default). The bit value is the 2-of-3 majority, decided at `smp_cnt` = 9 (the "decision point").
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: on `rxs_d`=1 and `rxs`=0 (falling edge), go to START with `smp_cnt`=0 in that cycle. Latch `par_en` and `par_typ`; changes to them mid-frame are ignored.
  - START: at the decision point, a majority of 1 is a glitch: return to IDLE and set `busy`=0 with no error flags. A majority of 0 continues. At `smp_cnt`=OVERSAMPLE-1, go to DATA with `bit_cnt`=0.
  - DATA: at each decision point, shift the bit into a shift register, LSB first. At the end of the bit, increment `bit_cnt`. After bit DATA_WIDTH-1, go to PARITY if latched `par_en`=1, else go to STOP.
  - PARITY: at the decision point, compare the sampled bit with ^data XOR `par_typ`. A mismatch sets an internal error bit. At the end of the bit, go to STOP.
  - STOP: at the decision point, evaluate the frame and go straight to IDLE. The FSM does not wait for the rest of the stop bit, so a start edge in the second half of the stop bit is accepted.
- **Frame result at the STOP decision point:**
  - Stop majority 0: pulse `stop_err`.
  - Parity error recorded: pulse `par_err`.
  - Both conditions can pulse in the same cycle.
  - No error: load `rx_data` from the shift register and pulse `data_valid`.
  - On any error, `rx_data` holds its old value.
- **Reset:** asynchronous assertion at any time, including mid-frame, forces IDLE, both counters to 0 and the shift register to 0. No partial frame is reported.

## Timing
- **Reset values:** `rx_data`=0, `data_valid`=0, `par_err`=0, `stop_err`=0, `busy`=0. Synchroniser flops = 1.
- **Edge detection:** an `rx_in` fall detected at clock edge E appears as `rxs`=0 after 2 edges. Falling-edge detection therefore happens 2–3 cycles after the line falls. Call the detection cycle D.
- **`busy`:** registered. Rises at D+1. Falls the cycle after the STOP decision point, or after a rejected start.
- **Output latency:** outputs are registered and valid one cycle after the decision point. `data_valid`, `par_err` and `stop_err` are high for exactly one cycle at D + N·OVERSAMPLE + OVERSAMPLE/2 + 2. Here N = 1 + DATA_WIDTH + `par_en` is the index of the stop bit. For 8N1 this is D+154; for 8E1 it is D+170.
- **Glitch filtering:** a low pulse of ≤ 6 cycles starting at D cannot reach the START decision point as 0. It is rejected with `busy` high for at most 10 cycles.
- **Back-to-back frames:** the minimum spacing between the next start-edge detection and the previous decision point is 1 cycle.

## Test plan
- **8N1 byte:** send 0xA5 at 16 cycles per bit with `par_en`=0. Expect `data_valid` for exactly 1 cycle at D+154, `rx_data`=0xA5, and no error flags.
- **8E1, correct and wrong parity:** send 0x3C with parity bit 0 (even parity). Expect `rx_data`=0x3C and `data_valid`. Then send 0x3C with parity bit 1. Expect `par_err`=1 for one cycle, no `data_valid`, and `rx_data` still 0x3C.
- **Framing error:** send 0x55 with the stop bit driven 0, then return the line high. Expect `stop_err` pulse, no `data_valid`, and the next frame (0x81) received correctly.
- **Start glitch:** drive `rx_in` low for 4 cycles, then high. Expect `busy` to drop within 10 cycles of D, no output pulses, and a following 0x7E frame received correctly.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0xFF. Expect all outputs 0 immediately and `busy`=0. After release, a clean 0x12 frame is received.
- **Back-to-back with jitter:** send 0x00, 0xFF, 0xC3 with no idle gap and bit periods of 15 and 17 cycles. Expect three `data_valid` pulses with the correct bytes.
